// File: rtl/alu_seq.sv
// Registered ALU with persistent C/Z/N flags, carry-chained ops, single-bit shifts.
// Define ALU_SEQ_MUL_EN to add the iterative shift-add multiplier (opcode 11) behind o_ready.
module alu_seq #(
    parameter int DATA_WIDTH   = 8,
    parameter int OPCODE_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   i_1,
    input  logic [DATA_WIDTH-1:0]   i_2,
    input  logic [OPCODE_WIDTH-1:0] op_code,
    input  logic                    ALU_ce,
    input  logic                    carry_we,
    output logic [DATA_WIDTH-1:0]   o_main,
    output logic [DATA_WIDTH-1:0]   o_high,
    output logic                    o_valid,
    output logic                    o_ready,
    output logic                    carry_out,
    output logic                    zero_out,
    output logic                    neg_out
);

    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_OR  = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_XOR = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_NOT = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADC = OPCODE_WIDTH'(7);
    localparam logic [OPCODE_WIDTH-1:0] OP_SBB = OPCODE_WIDTH'(8);
    localparam logic [OPCODE_WIDTH-1:0] OP_SHL = OPCODE_WIDTH'(9);
    localparam logic [OPCODE_WIDTH-1:0] OP_SHR = OPCODE_WIDTH'(10);

    logic [DATA_WIDTH-1:0] r_main;
    logic                  r_valid;
    logic                  r_c;
    logic                  r_z;
    logic                  r_n;

    logic [DATA_WIDTH:0]   w_ext_a;
    logic [DATA_WIDTH:0]   w_ext_b;
    logic [DATA_WIDTH:0]   w_ext_c;
    logic [DATA_WIDTH:0]   w_arith;
    logic [DATA_WIDTH-1:0] w_res;
    logic                  w_c;
    logic                  w_issue;

    assign w_ext_a = {1'b0, i_1};
    assign w_ext_b = {1'b0, i_2};
    assign w_ext_c = {{DATA_WIDTH{1'b0}}, r_c};

    // Single-cycle datapath; the top bit of the widened difference is the borrow.
    always_comb begin
        w_arith = '0;
        w_res   = i_2;
        w_c     = r_c;
        case (op_code)
            OP_ADD: begin w_arith = w_ext_a + w_ext_b;           w_res = w_arith[DATA_WIDTH-1:0]; w_c = w_arith[DATA_WIDTH]; end
            OP_ADC: begin w_arith = w_ext_a + w_ext_b + w_ext_c; w_res = w_arith[DATA_WIDTH-1:0]; w_c = w_arith[DATA_WIDTH]; end
            OP_SUB: begin w_arith = w_ext_a - w_ext_b;           w_res = w_arith[DATA_WIDTH-1:0]; w_c = w_arith[DATA_WIDTH]; end
            OP_SBB: begin w_arith = w_ext_a - w_ext_b - w_ext_c; w_res = w_arith[DATA_WIDTH-1:0]; w_c = w_arith[DATA_WIDTH]; end
            OP_AND: w_res = i_1 & i_2;
            OP_OR:  w_res = i_1 | i_2;
            OP_XOR: w_res = i_1 ^ i_2;
            OP_NOT: w_res = ~i_1;
            OP_SHL: begin w_res = {i_1[DATA_WIDTH-2:0], 1'b0}; w_c = i_1[DATA_WIDTH-1]; end
            OP_SHR: begin w_res = {1'b0, i_1[DATA_WIDTH-1:1]}; w_c = i_1[0]; end
            default: w_res = i_2;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    localparam logic [OPCODE_WIDTH-1:0] OP_MUL = OPCODE_WIDTH'(11);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);

    typedef enum logic [0:0] {IDLE, MUL_BUSY} state_t;

    state_t                  r_state;
    logic                    r_ready;
    logic [DATA_WIDTH-1:0]   r_high;
    logic [DATA_WIDTH-1:0]   r_mcand;
    logic [2*DATA_WIDTH-1:0] r_prod;
    logic [CW-1:0]           r_count;
    logic                    r_mul_we;

    logic                    w_accept;
    logic                    w_is_mul;
    logic [DATA_WIDTH:0]     w_step_sum;
    logic [2*DATA_WIDTH-1:0] w_prod_next;

    assign w_accept    = ALU_ce && r_ready;
    assign w_is_mul    = (op_code == OP_MUL);
    assign w_issue     = w_accept && !w_is_mul;
    // Upper half accumulates the multiplicand while the multiplier shifts out of the lower half.
    assign w_step_sum  = {1'b0, r_prod[2*DATA_WIDTH-1:DATA_WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
    assign w_prod_next = {w_step_sum, r_prod[DATA_WIDTH-1:1]};
    assign o_ready     = r_ready;
    assign o_high      = r_high;
`else
    assign w_issue     = ALU_ce;
    assign o_ready     = 1'b1;
    assign o_high      = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main   <= '0;
            r_valid  <= 1'b0;
            r_c      <= 1'b0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            r_state  <= IDLE;
            r_ready  <= 1'b1;
            r_high   <= '0;
            r_mcand  <= '0;
            r_prod   <= '0;
            r_count  <= '0;
            r_mul_we <= 1'b0;
`endif
        end else begin
            r_valid <= 1'b0;
            if (w_issue) begin
                r_main  <= w_res;
                r_valid <= 1'b1;
`ifdef ALU_SEQ_MUL_EN
                r_high  <= '0;
`endif
                if (carry_we) begin
                    r_c <= w_c;
                    r_z <= (w_res == '0);
                    r_n <= w_res[DATA_WIDTH-1];
                end
            end
`ifdef ALU_SEQ_MUL_EN
            case (r_state)
                IDLE: begin
                    if (w_accept && w_is_mul) begin
                        r_mcand  <= i_1;
                        r_prod   <= {{DATA_WIDTH{1'b0}}, i_2};
                        r_count  <= '0;
                        r_mul_we <= carry_we;
                        r_ready  <= 1'b0;
                        r_state  <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    r_prod  <= w_prod_next;
                    r_count <= r_count + 1'b1;
                    if (r_count == LAST_STEP) begin
                        r_main  <= w_prod_next[DATA_WIDTH-1:0];
                        r_high  <= w_prod_next[2*DATA_WIDTH-1:DATA_WIDTH];
                        r_valid <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                        if (r_mul_we) begin
                            r_c <= |w_prod_next[2*DATA_WIDTH-1:DATA_WIDTH];
                            r_z <= (w_prod_next == '0);
                            r_n <= w_prod_next[2*DATA_WIDTH-1];
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
`endif
        end
    end

    assign o_main    = r_main;
    assign o_valid   = r_valid;
    assign carry_out = r_c;
    assign zero_out  = r_z;
    assign neg_out   = r_n;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, parametrised successor to the combinational datapath ALU.
- Adds a persistent flag register (carry/borrow, zero, negative), carry-chained ops (ADC/SBB) and single-bit shifts.
- Adds an iterative multi-cycle multiplier behind a valid/ready-style handshake.
- Sits between the register file read ports and the write-back mux; the controller issues one op per accept.

Parameters:
- DATA_WIDTH, 8, operand/result width in bits (>=2).
- OPCODE_WIDTH, 4, op_code width (>=4 so every encoding below is reachable).

Ports:
- clk, input, 1, system clock; all state updates on its rising edge.
- rst, input, 1, asynchronous active-high reset.
- i_1, input, DATA_WIDTH, operand A.
- i_2, input, DATA_WIDTH, operand B.
- op_code, input, OPCODE_WIDTH, operation select.
- ALU_ce, input, 1, issue strobe; op accepted when ALU_ce && o_ready.
- carry_we, input, 1, sampled at accept; 1 = update flags on completion.
- o_main, output, DATA_WIDTH, result (MUL: low half).
- o_high, output, DATA_WIDTH, MUL high half; 0 for all other ops.
- o_valid, output, 1, one-cycle pulse when o_main/o_high/flags are updated.
- o_ready, output, 1, high when an op can be accepted.
- carry_out, output, 1, C flag.
- zero_out, output, 1, Z flag.
- neg_out, output, 1, N flag (MSB of o_main).

Behaviour:
- Reset (async assert, any state): o_main=0, o_high=0, o_valid=0, o_ready=1, C=Z=N=0, FSM->IDLE, multiplier registers cleared. An in-flight op is discarded with no o_valid.
- Encoding (unsigned): 0 ADD, 1 SUBTRACT, 2 AND_OP, 3 OR_OP, 4 XOR_OP, 5 NOT_OP(~i_1), 6 LOAD(i_2), 7 ADC, 8 SBB, 9 SHL, 10 SHR, 11 MUL. Any other value behaves as LOAD.
- Arithmetic is computed at DATA_WIDTH+1 bits.
  - ADD: {C,r}=i_1+i_2.
  - ADC: {C,r}=i_1+i_2+C.
  - SUBTRACT: r=i_1-i_2, C=borrow (1 iff i_1<i_2).
  - SBB: r=i_1-i_2-C, C=borrow (1 iff i_1 < i_2+C).
  - SHL: r=i_1<<1, C=i_1[MSB].
  - SHR: logical, r=i_1>>1, C=i_1[0].
  - Logic/NOT/LOAD: C unchanged.
- Z=(r==0) and N=r[MSB] for every op. For MUL, Z covers the full 2*DATA_WIDTH product, N=o_high[MSB], C=(o_high!=0).
- Flags update only when the captured carry_we=1. With carry_we=0, results still update and flags hold.
- FSM states: IDLE, MUL_BUSY.
  - IDLE: on accept of a non-MUL op, o_main/o_high/flags are registered at that edge and o_valid=1 in the next cycle (latency 1). Back-to-back accepts every cycle are allowed. ADC/SBB use the C flag as already updated by the immediately preceding op.
  - IDLE on accept of MUL: capture operands, o_ready->0, go to MUL_BUSY.
  - MUL_BUSY: one shift-add step per cycle, DATA_WIDTH steps. On the final step, write o_high/o_main and flags, o_valid=1 in the following cycle together with o_ready=1, return to IDLE. MUL latency = DATA_WIDTH+1 cycles from accept to o_valid.
- ALU_ce while o_ready=0 is ignored: no queueing, no side effects.
- Outputs hold their last value between o_valid pulses.

Optional Feature:
- Macro ALU_SEQ_MUL_EN.
- Defined: MUL (11) is implemented as above; the MUL_BUSY state and multiplier registers exist.
- Undefined: opcode 11 decodes as LOAD (latency 1). o_ready is tied high. o_high is constant 0. No multiplier logic is synthesised.

Test Plan:
- ADD i_1=0xF0 i_2=0x20 carry_we=1 -> next cycle o_valid=1, o_main=0x10, C=1, Z=0, N=0.
- ADC i_1=0x01 i_2=0x01 issued directly after the previous ADD -> o_main=0x03, C=0. Repeat with carry_we=0 after an overflowing ADD -> C stays 1.
- SUBTRACT 0x05-0x05 -> o_main=0x00, Z=1, C=0. Then SBB 0x03-0x04 -> o_main=0xFF, C=1, N=1.
- MUL 0xFF*0xFF (macro defined) -> o_ready=0 for 8 cycles; ALU_ce pulses during busy are ignored. o_valid at cycle 9: o_high=0xFE, o_main=0x01, C=1, Z=0.
- rst asserted 4 cycles into a MUL -> all outputs 0 immediately, no o_valid. After release, o_ready=1 and ADD 0x01+0x01 -> 0x02.
- Opcode 0xF with i_2=0x5A -> o_main=0x5A, C unchanged. Macro undefined: opcode 11 with i_2=0x33 -> o_main=0x33, latency 1, o_high=0.
